// File: rtl/rgmii_rx_pkg.sv
// Shared types and constants for the RGMII receive framer.
// The CRC constants are used only when RGMII_RX_FCS_CHECK_EN is defined.
package rgmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 advanced by one byte per cycle, LSB of the byte first.
// Only built when RGMII_RX_FCS_CHECK_EN is defined.
`ifdef RGMII_RX_FCS_CHECK_EN
module crc32_d8
  import rgmii_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      crc_o = (crc_o >> 1) ^ (CRC32_POLY & {32{crc_o[0] ^ data_i[i]}});
    end
  end

endmodule
`endif

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, assembles bytes (1000 or 10/100), reports length and errors.
// Define RGMII_RX_FCS_CHECK_EN to add the FCS residue check on o_rx_crc_err.
//
// state    | meaning
// ST_DROP  | after reset, wait for rx_dv low so no partial frame is taken
// ST_IDLE  | between frames, looking for the first preamble symbol
// ST_PREAMB| preamble seen, waiting for the SFD
// ST_DATA  | delivering frame bytes until rx_dv falls
module rgmii_rx_framer
  import rgmii_rx_pkg::*;
#(
  parameter int P_MAX_LEN = 1526,
  parameter int P_LEN_W   = 11
) (
  input  logic               i_rxc,
  input  logic               i_rst_n,
  input  logic               i_speed1000,
  input  logic [7:0]         i_ddr_data,
  input  logic [1:0]         i_ddr_ctl,
  output logic [7:0]         o_rx_data,
  output logic               o_rx_valid,
  output logic               o_rx_end,
  output logic [P_LEN_W-1:0] o_rx_len,
  output logic               o_rx_err,
  output logic               o_rx_crc_err
);

  localparam logic [P_LEN_W-1:0] MAX_LEN = P_LEN_W'(P_MAX_LEN);

  logic               rx_dv, rx_er;
  rx_state_e          state_q, state_d;
  logic               speed_q, speed_d;
  logic               nib_ph_q, nib_ph_d;
  logic [3:0]         nib_lo_q, nib_lo_d;
  logic [P_LEN_W-1:0] len_q, len_d;
  logic               err_q, err_d;
  logic [7:0]         s1_data_q, s1_data_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_end_q, s1_end_d;
  logic               byte_done;
  logic [7:0]         byte_val;
  logic               is_pre, is_sfd;

  assign rx_dv = i_ddr_ctl[0];
  assign rx_er = i_ddr_ctl[1] ^ i_ddr_ctl[0];

  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    nib_ph_d  = nib_ph_q;
    nib_lo_d  = nib_lo_q;
    len_d     = len_q;
    err_d     = err_q;
    s1_data_d = s1_data_q;
    s1_vld_d  = 1'b0;
    s1_end_d  = 1'b0;
    byte_done = 1'b0;
    byte_val  = speed_q ? i_ddr_data : {i_ddr_data[3:0], nib_lo_q};
    // In nibble mode the SFD is identified by its high nibble; low nibbles equal preamble.
    is_pre    = speed_q ? (i_ddr_data == PREAMBLE_BYTE) : (i_ddr_data[3:0] == PREAMBLE_BYTE[3:0]);
    is_sfd    = speed_q ? (i_ddr_data == SFD_BYTE)      : (i_ddr_data[3:0] == SFD_BYTE[7:4]);
    case (state_q)
      ST_DROP: if (!rx_dv) state_d = ST_IDLE;
      ST_IDLE: begin
        if (rx_dv && (i_speed1000 ? (i_ddr_data == PREAMBLE_BYTE)
                                  : (i_ddr_data[3:0] == PREAMBLE_BYTE[3:0]))) begin
          state_d = ST_PREAMBLE;
          speed_d = i_speed1000;
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv) begin
          state_d = ST_IDLE;
        end else if (is_sfd) begin
          state_d  = ST_DATA;
          len_d    = '0;
          err_d    = 1'b0;
          nib_ph_d = 1'b0;
        end else if (!is_pre) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!rx_dv) begin
          state_d  = ST_IDLE;
          s1_end_d = 1'b1;
          if (nib_ph_q || (len_q == '0)) err_d = 1'b1;
        end else begin
          if (rx_er) err_d = 1'b1;
          if (speed_q || nib_ph_q) byte_done = 1'b1;
          else nib_lo_d = i_ddr_data[3:0];
          if (!speed_q) nib_ph_d = ~nib_ph_q;
          if (byte_done) begin
            if (len_q == MAX_LEN) begin
              err_d = 1'b1;
            end else begin
              s1_vld_d  = 1'b1;
              s1_data_d = byte_val;
              len_d     = len_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_DROP;
    endcase
  end

  always_ff @(posedge i_rxc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_DROP;
      speed_q    <= 1'b0;
      nib_ph_q   <= 1'b0;
      nib_lo_q   <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      s1_data_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_end_q   <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_rx_end   <= 1'b0;
      o_rx_len   <= '0;
      o_rx_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      nib_ph_q   <= nib_ph_d;
      nib_lo_q   <= nib_lo_d;
      len_q      <= len_d;
      err_q      <= err_d;
      s1_data_q  <= s1_data_d;
      s1_vld_q   <= s1_vld_d;
      s1_end_q   <= s1_end_d;
      o_rx_valid <= s1_vld_q;
      if (s1_vld_q) o_rx_data <= s1_data_q;
      o_rx_end   <= s1_end_q;
      o_rx_len   <= s1_end_q ? len_q : '0;
      o_rx_err   <= s1_end_q & err_q;
    end
  end

`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_upd;

  crc32_d8 u_crc32_d8 (
    .crc_i  (crc_q),
    .data_i (s1_data_d),
    .crc_o  (crc_upd)
  );

  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_PREAMBLE && state_d == ST_DATA) crc_d = CRC32_INIT;
    else if (s1_vld_d) crc_d = crc_upd;
  end

  always_ff @(posedge i_rxc or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q        <= CRC32_INIT;
      o_rx_crc_err <= 1'b0;
    end else begin
      crc_q        <= crc_d;
      o_rx_crc_err <= s1_end_q && (crc_q != CRC32_RESIDUE);
    end
  end
`else
  assign o_rx_crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer: byte/nibble frames, errors, oversize, reset and preamble cases.
module tb_rgmii_rx_framer;

  localparam int MAXL = 1526;
`ifdef RGMII_RX_FCS_CHECK_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  logic        i_rxc = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_speed1000 = 1'b1;
  logic [7:0]  i_ddr_data = '0;
  logic [1:0]  i_ddr_ctl = '0;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid, o_rx_end, o_rx_err, o_rx_crc_err;
  logic [10:0] o_rx_len;

  rgmii_rx_framer dut (
    .i_rxc(i_rxc), .i_rst_n(i_rst_n), .i_speed1000(i_speed1000),
    .i_ddr_data(i_ddr_data), .i_ddr_ctl(i_ddr_ctl),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_end(o_rx_end),
    .o_rx_len(o_rx_len), .o_rx_err(o_rx_err), .o_rx_crc_err(o_rx_crc_err)
  );

  always #5 i_rxc = ~i_rxc;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int vcount = 0, first_vcyc = -1, last_vcyc = -1;
  int end_cnt = 0, end_cyc = -1;
  int d_first = 0, d_last = 0;
  logic [10:0] end_len = '0;
  logic        end_err = 1'b0, end_crc = 1'b0;
  logic [7:0]  last_data = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  frm[0:1599];

  always @(posedge i_rxc) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid byte, records end-of-frame fields.
  always @(posedge i_rxc) begin
    logic [7:0] e;
    #1;
    if (!i_rst_n) begin
      last_data = '0;
    end else begin
      if (o_rx_valid) begin
        n_checks++;
        if (o_rx_end !== 1'b0) begin
          n_fail++; $display("FAIL end_with_valid at cycle %0d", cyc);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_valid data %h at cycle %0d", o_rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (o_rx_data !== e) begin
            n_fail++; $display("FAIL rx_data got %h want %h at cycle %0d", o_rx_data, e, cyc);
          end
        end
        vcount++;
        if (vcount == 1) first_vcyc = cyc;
        last_vcyc = cyc;
        last_data = o_rx_data;
      end else begin
        n_checks++;
        if (o_rx_data !== last_data) begin
          n_fail++; $display("FAIL data_hold got %h want %h at cycle %0d", o_rx_data, last_data, cyc);
        end
      end
      if (o_rx_end) begin
        end_cnt++;
        end_cyc = cyc;
        end_len = o_rx_len;
        end_err = o_rx_err;
        end_crc = o_rx_crc_err;
      end
    end
  end

  function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int n, input bit good_fcs);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) frm[i] = 8'($urandom_range(0, 255));
    if (good_fcs) begin
      for (int i = 0; i < n - 4; i++) c = crc_add(c, frm[i]);
      c = ~c;
      frm[n-4] = c[7:0];   frm[n-3] = c[15:8];
      frm[n-2] = c[23:16]; frm[n-1] = c[31:24];
    end
  endtask

  task automatic drive_byte(input bit spd, input logic [7:0] b, input bit dv, input bit er);
    i_speed1000 = spd;
    if (spd) begin
      @(negedge i_rxc);
      i_ddr_data = b; i_ddr_ctl = {dv ^ er, dv};
    end else begin
      @(negedge i_rxc);
      i_ddr_data = {~b[3:0], b[3:0]}; i_ddr_ctl = {dv ^ er, dv};
      @(negedge i_rxc);
      i_ddr_data = {~b[7:4], b[7:4]}; i_ddr_ctl = {dv ^ er, dv};
    end
  endtask

  task automatic drive_idle();
    @(negedge i_rxc);
    i_ddr_data = '0; i_ddr_ctl = 2'b00;
  endtask

  task automatic clear_mon();
    vcount = 0; first_vcyc = -1; last_vcyc = -1;
    end_cnt = 0; end_cyc = -1; end_len = '0; end_err = 1'b0; end_crc = 1'b0;
  endtask

  task automatic send_frame(input bit spd, input int n, input int er_idx, input bit odd_nib);
    for (int k = 0; k < 7; k++) drive_byte(spd, 8'h55, 1'b1, 1'b0);
    drive_byte(spd, 8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i < MAXL) exp_q.push_back(frm[i]);
      drive_byte(spd, frm[i], 1'b1, i == er_idx);
      if (i == 0) d_first = cyc;
      d_last = cyc;
    end
    if (odd_nib) begin
      @(negedge i_rxc);
      i_ddr_data = 8'h0A; i_ddr_ctl = 2'b01;
    end
    drive_idle();
  endtask

  task automatic wait_end(input int n);
    for (int k = 0; k < 60 && end_cnt < n; k++) @(negedge i_rxc);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_rxc);
    n_checks++;
    if ({o_rx_valid, o_rx_end, o_rx_err, o_rx_crc_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {o_rx_valid, o_rx_end, o_rx_err, o_rx_crc_err});
    end
    n_checks++;
    if (o_rx_len !== 11'd0 || o_rx_data !== 8'd0) begin
      n_fail++; $display("FAIL reset_len_data got %0d/%h want 0/00", o_rx_len, o_rx_data);
    end
    @(negedge i_rxc); i_rst_n = 1'b1;
    repeat (3) drive_idle();
  endtask

  task automatic test_byte_frame();
    clear_mon(); build_frame(64, 1'b1);
    send_frame(1'b1, 64, -1, 1'b0); wait_end(1);
    n_checks++; if (vcount !== 64) begin n_fail++; $display("FAIL byte_vcount got %0d want 64", vcount); end
    n_checks++; if (first_vcyc !== d_first + 2) begin n_fail++; $display("FAIL byte_latency got %0d want %0d", first_vcyc, d_first + 2); end
    n_checks++; if (last_vcyc !== d_first + 65) begin n_fail++; $display("FAIL byte_contig got %0d want %0d", last_vcyc, d_first + 65); end
    n_checks++; if (end_cnt !== 1) begin n_fail++; $display("FAIL byte_end_cnt got %0d want 1", end_cnt); end
    n_checks++; if (end_cyc !== d_last + 3) begin n_fail++; $display("FAIL byte_end_cyc got %0d want %0d", end_cyc, d_last + 3); end
    n_checks++; if (end_len !== 11'd64) begin n_fail++; $display("FAIL byte_len got %0d want 64", end_len); end
    n_checks++; if ({end_err, end_crc} !== 2'b00) begin n_fail++; $display("FAIL byte_err_crc got %b want 00", {end_err, end_crc}); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL byte_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_nibble_frame();
    clear_mon(); build_frame(64, 1'b1);
    send_frame(1'b0, 64, -1, 1'b0); wait_end(1);
    n_checks++; if (vcount !== 64) begin n_fail++; $display("FAIL nib_vcount got %0d want 64", vcount); end
    n_checks++; if (first_vcyc !== d_first + 2) begin n_fail++; $display("FAIL nib_latency got %0d want %0d", first_vcyc, d_first + 2); end
    n_checks++; if (last_vcyc !== first_vcyc + 126) begin n_fail++; $display("FAIL nib_spacing got %0d want %0d", last_vcyc, first_vcyc + 126); end
    n_checks++; if (end_len !== 11'd64) begin n_fail++; $display("FAIL nib_len got %0d want 64", end_len); end
    n_checks++; if ({end_err, end_crc} !== 2'b00) begin n_fail++; $display("FAIL nib_err_crc got %b want 00", {end_err, end_crc}); end
  endtask

  task automatic test_rx_er_and_fcs();
    clear_mon(); build_frame(64, 1'b1);
    send_frame(1'b1, 64, 10, 1'b0); wait_end(1);
    n_checks++; if (vcount !== 64) begin n_fail++; $display("FAIL er_vcount got %0d want 64", vcount); end
    n_checks++; if (end_err !== 1'b1) begin n_fail++; $display("FAIL er_err got %b want 1", end_err); end
    n_checks++; if (end_crc !== 1'b0) begin n_fail++; $display("FAIL er_crc got %b want 0", end_crc); end
    clear_mon(); build_frame(64, 1'b1); frm[62] = frm[62] ^ 8'h01;
    send_frame(1'b1, 64, -1, 1'b0); wait_end(1);
    n_checks++; if (end_crc !== FCS_ON) begin n_fail++; $display("FAIL fcs_bad_crc got %b want %b", end_crc, FCS_ON); end
    n_checks++; if (end_err !== 1'b0 || end_len !== 11'd64) begin n_fail++; $display("FAIL fcs_bad_err_len got %b/%0d want 0/64", end_err, end_len); end
  endtask

  task automatic test_oversize();
    clear_mon(); build_frame(1600, 1'b0);
    send_frame(1'b1, 1600, -1, 1'b0); wait_end(1);
    n_checks++; if (vcount !== MAXL) begin n_fail++; $display("FAIL over_vcount got %0d want %0d", vcount, MAXL); end
    n_checks++; if (end_len !== 11'(MAXL)) begin n_fail++; $display("FAIL over_len got %0d want %0d", end_len, MAXL); end
    n_checks++; if (end_err !== 1'b1) begin n_fail++; $display("FAIL over_err got %b want 1", end_err); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL over_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    clear_mon(); build_frame(64, 1'b1);
    for (int k = 0; k < 7; k++) drive_byte(1'b1, 8'h55, 1'b1, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i < 19) exp_q.push_back(frm[i]);
      drive_byte(1'b1, frm[i], 1'b1, 1'b0);
      if (i == 20) i_rst_n = 1'b0;
      if (i == 25) begin
        #1;
        n_checks++;
        if ({o_rx_valid, o_rx_end, o_rx_err, o_rx_crc_err} !== 4'b0 || o_rx_len !== 11'd0 || o_rx_data !== 8'd0) begin
          n_fail++; $display("FAIL rst_mid_outputs got %b/%0d/%h want 0", {o_rx_valid, o_rx_end, o_rx_err, o_rx_crc_err}, o_rx_len, o_rx_data);
        end
      end
      if (i == 30) i_rst_n = 1'b1;
    end
    repeat (10) drive_idle();
    n_checks++; if (end_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_end got %0d want 0", end_cnt); end
    n_checks++; if (vcount !== 19) begin n_fail++; $display("FAIL rst_mid_vcount got %0d want 19", vcount); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_sb_left got %0d want 0", exp_q.size()); end
    clear_mon(); build_frame(64, 1'b1);
    send_frame(1'b1, 64, -1, 1'b0); wait_end(1);
    n_checks++; if (end_cnt !== 1 || end_len !== 11'd64) begin n_fail++; $display("FAIL rst_next_frame got %0d/%0d want 1/64", end_cnt, end_len); end
    n_checks++; if ({end_err, end_crc} !== 2'b00) begin n_fail++; $display("FAIL rst_next_err got %b want 00", {end_err, end_crc}); end
  endtask

  task automatic test_bad_preamble();
    clear_mon();
    drive_byte(1'b1, 8'h55, 1'b1, 1'b0);
    drive_byte(1'b1, 8'h55, 1'b1, 1'b0);
    drive_byte(1'b1, 8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) drive_byte(1'b1, 8'(32 + i), 1'b1, 1'b0);
    repeat (10) drive_idle();
    n_checks++; if (vcount !== 0) begin n_fail++; $display("FAIL badpre_vcount got %0d want 0", vcount); end
    n_checks++; if (end_cnt !== 0) begin n_fail++; $display("FAIL badpre_end got %0d want 0", end_cnt); end
  endtask

  task automatic test_odd_nibble();
    clear_mon(); build_frame(20, 1'b0);
    send_frame(1'b0, 20, -1, 1'b1); wait_end(1);
    n_checks++; if (vcount !== 20) begin n_fail++; $display("FAIL odd_vcount got %0d want 20", vcount); end
    n_checks++; if (end_cnt !== 1 || end_len !== 11'd20) begin n_fail++; $display("FAIL odd_len got %0d/%0d want 1/20", end_cnt, end_len); end
    n_checks++; if (end_err !== 1'b1) begin n_fail++; $display("FAIL odd_err got %b want 1", end_err); end
  endtask

  task automatic test_zero_byte();
    clear_mon();
    send_frame(1'b1, 0, -1, 1'b0); wait_end(1);
    n_checks++; if (end_cnt !== 1 || end_len !== 11'd0) begin n_fail++; $display("FAIL zero_len got %0d/%0d want 1/0", end_cnt, end_len); end
    n_checks++; if (end_err !== 1'b1 || vcount !== 0) begin n_fail++; $display("FAIL zero_err got %b/%0d want 1/0", end_err, vcount); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_frame(64, 1'b1); send_frame(1'b1, 64, -1, 1'b0);
    build_frame(64, 1'b1); send_frame(1'b0, 64, -1, 1'b0);
    wait_end(2);
    n_checks++; if (end_cnt !== 2) begin n_fail++; $display("FAIL b2b_end_cnt got %0d want 2", end_cnt); end
    n_checks++; if (vcount !== 128) begin n_fail++; $display("FAIL b2b_vcount got %0d want 128", vcount); end
    n_checks++; if (end_len !== 11'd64 || {end_err, end_crc} !== 2'b00) begin n_fail++; $display("FAIL b2b_last got %0d/%b want 64/00", end_len, {end_err, end_crc}); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_sb_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_byte_frame();
    test_nibble_frame();
    test_rx_er_and_fcs();
    test_oversize();
    test_reset_mid();
    test_bad_preamble();
    test_odd_nibble();
    test_zero_byte();
    test_back_to_back();
    repeat (5) drive_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgmii_rx_framer.md
RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 SHALL have parameter P_MAX_LEN, default 1526, maximum bytes delivered per frame (receive RAM depth).
REQ-002 SHALL have parameter P_LEN_W, default 11, width of the length counter.
REQ-003 SHALL have port i_rxc  in  1  receive clock; the only clock.
REQ-004 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_speed1000  in  1  1 = gigabit byte mode, 0 = 10/100 nibble mode.
REQ-006 SHALL have port i_ddr_data  in  8  IDDR output: [3:0] rising-edge nibble, [7:4] falling-edge nibble.
REQ-007 SHALL have port i_ddr_ctl  in  2  IDDR output: [0] rx_dv, [1] rx_dv XOR rx_er.
REQ-008 SHALL have port o_rx_data  out  8  frame byte after SFD; FCS is included.
REQ-009 SHALL have port o_rx_valid  out  1  o_rx_data qualifier.
REQ-010 SHALL have port o_rx_end  out  1  one-cycle pulse after the last o_rx_valid of a frame.
REQ-011 SHALL have port o_rx_len  out  P_LEN_W  delivered byte count, valid while o_rx_end=1.
REQ-012 SHALL have port o_rx_err  out  1  frame error flag, valid while o_rx_end=1.
REQ-013 SHALL have port o_rx_crc_err  out  1  FCS mismatch, valid while o_rx_end=1.

Function
REQ-014 SHALL decode rx_er as i_ddr_ctl[1]^i_ddr_ctl[0] every cycle.
REQ-015 SHALL implement states DROP, IDLE, PREAMBLE, DATA.
  - DROP->IDLE when rx_dv=0.
  - IDLE->PREAMBLE on rx_dv=1 with preamble symbol 0x55 (nibble 0x5).
  - PREAMBLE->DATA on SFD 0xD5 (1000: byte 0xD5; 10/100: nibble 0x5 then nibble 0xD).
  - PREAMBLE->IDLE on rx_dv=0, or on any symbol other than preamble/SFD, with no output.
  - DATA->IDLE on rx_dv=0.
REQ-016 SHALL latch i_speed1000 on IDLE->PREAMBLE and hold it for the whole frame.
REQ-017 In byte mode, SHALL form each byte as {i_ddr_data[7:4], i_ddr_data[3:0]}, one byte per cycle.
REQ-018 In nibble mode, SHALL use only i_ddr_data[3:0], low nibble first; byte alignment is fixed by the SFD high nibble.
REQ-019 SHALL present o_rx_valid exactly 2 cycles after the input cycle that completes the byte.
REQ-020 SHALL keep o_rx_valid contiguous in byte mode and asserted every second cycle in nibble mode.
REQ-021 SHALL assert o_rx_end 1 cycle after the last o_rx_valid.
  - o_rx_end SHALL never coincide with o_rx_valid.
  - A new SFD may be accepted in the cycle o_rx_end is high.
REQ-022 SHALL count delivered bytes in o_rx_len, saturating at P_MAX_LEN.
REQ-023 Bytes beyond P_MAX_LEN SHALL be dropped (o_rx_valid=0) and SHALL set o_rx_err.
REQ-024 SHALL set o_rx_err on any of the following; the flag clears after o_rx_end:
  - rx_er=1 during DATA;
  - a trailing odd nibble at rx_dv fall in nibble mode (the partial nibble is discarded);
  - a zero-byte frame (o_rx_end still pulses, with o_rx_len=0).
REQ-025 SHALL hold o_rx_data at its last value while o_rx_valid=0.

Reset
REQ-026 On i_rst_n=0, SHALL asynchronously set all outputs to 0, state to DROP, and the CRC register to 32'hFFFFFFFF.
REQ-027 After reset releases mid-frame, SHALL stay in DROP until rx_dv=0; no partial frame and no o_rx_end are produced.

Configuration
REQ-028 Macro RGMII_RX_FCS_CHECK_EN defined: SHALL compute a reflected CRC-32 (polynomial 32'hEDB88320, init all-ones) over every delivered byte.
  - o_rx_crc_err = (register != 32'hDEBB20E3) at o_rx_end.
REQ-029 Macro RGMII_RX_FCS_CHECK_EN undefined: SHALL omit CRC logic and tie o_rx_crc_err to 0.

Structure
REQ-030 Package rgmii_rx_pkg SHALL hold:
  - the state enum typedef;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
REQ-031 SHALL instantiate sub-module crc32_d8 (8-bit-per-cycle CRC update) only under RGMII_RX_FCS_CHECK_EN.

Verification
REQ-032 Byte mode: 7x 0x55, 0xD5, 64 bytes with valid FCS.
  - o_rx_valid is high for 64 consecutive cycles, starting 2 cycles after the first byte.
  - o_rx_end pulses with o_rx_len=64, o_rx_err=0, o_rx_crc_err=0.
REQ-033 Nibble mode: same frame as nibbles.
  - 64 bytes are delivered, with o_rx_valid every 2nd cycle and correct low-first assembly.
  - o_rx_len=64.
REQ-034 Byte mode: rx_er pulsed on data byte 10 of a 64-byte frame.
  - All 64 bytes are delivered; o_rx_end shows o_rx_err=1.
  - Corrupting one FCS byte -> o_rx_crc_err=1 (macro on), 0 (macro off).
REQ-035 Byte mode: 1600-byte frame -> exactly 1526 o_rx_valid pulses; o_rx_len=1526, o_rx_err=1.
REQ-036 i_rst_n asserted at data byte 20 and released at byte 30.
  - Outputs are 0 during reset; no o_rx_end is produced for that frame.
  - The next frame after rx_dv=0 is received normally.
REQ-037 Preamble 0x55 0x55 0x12 then data -> no o_rx_valid and no o_rx_end.
  - Nibble mode, frame ending on an odd nibble -> o_rx_err=1, with o_rx_len equal to the whole-byte count.
